// File: rtl/ar_r_channel_if.sv
// AXI read-address / read-data channel bundle for the SRAM-like read bridge.
// The bridge drives the master side; the AXI slave (interconnect or memory) drives the slave side.
interface ar_r_channel_if;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [1:0]  arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
      input  arready, rid, rdata, rresp, rlast, rvalid
   );

   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
      output arready, rid, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/ar_r_channel.sv
// Read half of the SRAM-like-to-AXI bridge: arbitrates inst/data reads (data first),
// issues single-beat AR transactions one at a time and returns R data with a registered data_ok.
module ar_r_channel #(
   parameter logic [3:0] INST_ID = 4'd0,
   parameter logic [3:0] DATA_ID = 4'd1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_sram_req,
   input  logic        inst_sram_wr,
   input  logic [1:0]  inst_sram_size,
   input  logic [31:0] inst_sram_addr,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [31:0] data_sram_addr,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata,
   input  logic        write_busy,
   ar_r_channel_if.master axi
);
   typedef enum logic [1:0] {IDLE, AR, R, RESP} state_e;

   state_e      state_q, state_d;
   logic        src_q, src_d;          // 1: transaction belongs to the data port
   logic        arvalid_q, arvalid_d;
   logic        rready_q, rready_d;
   logic [3:0]  arid_q, arid_d;
   logic [31:0] araddr_q, araddr_d;
   logic [1:0]  size_q, size_d;
   logic [31:0] inst_rdata_q, inst_rdata_d;
   logic [31:0] data_rdata_q, data_rdata_d;
   logic        inst_ok_q, inst_ok_d;
   logic        data_ok_q, data_ok_d;

   logic inst_rd, data_rd;
   // Holding data reads while a write is in flight keeps reads from overtaking it.
   assign inst_rd = inst_sram_req && !inst_sram_wr;
   assign data_rd = data_sram_req && !data_sram_wr && !write_busy;

   always_comb begin
      state_d      = state_q;
      src_d        = src_q;
      arvalid_d    = arvalid_q;
      rready_d     = rready_q;
      arid_d       = arid_q;
      araddr_d     = araddr_q;
      size_d       = size_q;
      inst_rdata_d = inst_rdata_q;
      data_rdata_d = data_rdata_q;
      inst_ok_d    = 1'b0;
      data_ok_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (data_rd) begin
               src_d     = 1'b1;
               arid_d    = DATA_ID;
               araddr_d  = data_sram_addr;
               size_d    = data_sram_size;
               arvalid_d = 1'b1;
               state_d   = AR;
            end else if (inst_rd) begin
               src_d     = 1'b0;
               arid_d    = INST_ID;
               araddr_d  = inst_sram_addr;
               size_d    = inst_sram_size;
               arvalid_d = 1'b1;
               state_d   = AR;
            end
         end
         AR: begin
            if (arvalid_q && axi.arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = R;
            end
         end
         R: begin
            // rid is not consulted: with one read outstanding, src alone routes the beat.
            if (axi.rvalid && rready_q) begin
               if (src_q) data_rdata_d = axi.rdata;
               else       inst_rdata_d = axi.rdata;
               data_ok_d = src_q;
               inst_ok_d = !src_q;
               rready_d  = 1'b0;
               state_d   = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         src_q        <= 1'b0;
         arvalid_q    <= 1'b0;
         rready_q     <= 1'b0;
         arid_q       <= '0;
         araddr_q     <= '0;
         size_q       <= '0;
         inst_rdata_q <= '0;
         data_rdata_q <= '0;
         inst_ok_q    <= 1'b0;
         data_ok_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         arvalid_q    <= arvalid_d;
         rready_q     <= rready_d;
         arid_q       <= arid_d;
         araddr_q     <= araddr_d;
         size_q       <= size_d;
         inst_rdata_q <= inst_rdata_d;
         data_rdata_q <= data_rdata_d;
         inst_ok_q    <= inst_ok_d;
         data_ok_q    <= data_ok_d;
      end
   end

   assign inst_sram_addr_ok = (state_q == AR) && axi.arready && !src_q;
   assign data_sram_addr_ok = (state_q == AR) && axi.arready &&  src_q;
   assign inst_sram_data_ok = inst_ok_q;
   assign data_sram_data_ok = data_ok_q;
   assign inst_sram_rdata   = inst_rdata_q;
   assign data_sram_rdata   = data_rdata_q;

   assign axi.arid    = arid_q;
   assign axi.araddr  = araddr_q;
   assign axi.arlen   = 8'd0;
   assign axi.arsize  = {1'b0, size_q};
   assign axi.arburst = 2'b01;
   assign axi.arlock  = 2'b00;
   assign axi.arcache = 4'd0;
   assign axi.arprot  = 3'd0;
   assign axi.arvalid = arvalid_q;
   assign axi.rready  = rready_q;

   logic unused_r;
   assign unused_r = ^{axi.rid, axi.rresp, axi.rlast};
endmodule

// File: tb/tb_ar_r_channel.sv
// Bench for ar_r_channel: an AXI read slave model plus a scoreboard of expected AR and
// data_ok events, stepped once per cycle (drive after posedge, observe on negedge).
module tb_ar_r_channel;
   localparam logic [3:0] INST_ID = 4'd0;
   localparam logic [3:0] DATA_ID = 4'd1;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        inst_sram_req = 1'b0, inst_sram_wr = 1'b0;
   logic [1:0]  inst_sram_size = 2'd0;
   logic [31:0] inst_sram_addr = 32'd0;
   logic        inst_sram_addr_ok, inst_sram_data_ok;
   logic [31:0] inst_sram_rdata;
   logic        data_sram_req = 1'b0, data_sram_wr = 1'b0;
   logic [1:0]  data_sram_size = 2'd0;
   logic [31:0] data_sram_addr = 32'd0;
   logic        data_sram_addr_ok, data_sram_data_ok;
   logic [31:0] data_sram_rdata;
   logic        write_busy = 1'b0;

   ar_r_channel_if axi();

   always #5 clk = ~clk;

   ar_r_channel #(.INST_ID(INST_ID), .DATA_ID(DATA_ID)) dut (
      .clk               (clk),
      .resetn            (resetn),
      .inst_sram_req     (inst_sram_req),
      .inst_sram_wr      (inst_sram_wr),
      .inst_sram_size    (inst_sram_size),
      .inst_sram_addr    (inst_sram_addr),
      .inst_sram_addr_ok (inst_sram_addr_ok),
      .inst_sram_data_ok (inst_sram_data_ok),
      .inst_sram_rdata   (inst_sram_rdata),
      .data_sram_req     (data_sram_req),
      .data_sram_wr      (data_sram_wr),
      .data_sram_size    (data_sram_size),
      .data_sram_addr    (data_sram_addr),
      .data_sram_addr_ok (data_sram_addr_ok),
      .data_sram_data_ok (data_sram_data_ok),
      .data_sram_rdata   (data_sram_rdata),
      .write_busy        (write_busy),
      .axi               (axi)
   );

   typedef struct {
      logic        is_data;
      logic [31:0] addr;
      logic [1:0]  size;
   } req_t;

   req_t exp_ar[$];
   req_t exp_r[$];

   int checks = 0, errors = 0;
   int cyc = 0;
   int ar_stall = 0, r_delay = 1;
   int stall_cnt = 0, r_wait = 0;
   logic s_busy = 1'b0;
   int inst_aok_cnt = 0, data_aok_cnt = 0, inst_ok_cnt = 0, data_ok_cnt = 0;
   int r_hs_cyc = -10;
   logic [31:0] exp_inst_rdata = 32'd0, exp_data_rdata = 32'd0;
   logic last_aok_i = 1'b0, last_aok_d = 1'b0, ar_hs_prev = 1'b0, r_hs_prev = 1'b0;
   logic [31:0] hs_addr = 32'd0;
   logic [3:0]  hs_id = 4'd0;
   logic prev_wait = 1'b0;
   logic [31:0] prev_araddr = 32'd0;
   logic [3:0]  prev_arid = 4'd0;
   logic [2:0]  prev_arsize = 3'd0;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return (a == 32'h1FC0_0000) ? 32'h3C1D_0000 : (a ^ 32'h5A5A_1234);
   endfunction

   // AXI slave model and requester address-phase release, driven just after posedge.
   task automatic slave_step();
      if (!resetn) begin
         axi.arready = 1'b0;
         axi.rvalid  = 1'b0;
         s_busy      = 1'b0;
         stall_cnt   = 0;
         return;
      end
      if (last_aok_i) inst_sram_req = 1'b0;
      if (last_aok_d) data_sram_req = 1'b0;
      if (r_hs_prev) begin
         axi.rvalid = 1'b0;
         s_busy     = 1'b0;
      end
      if (ar_hs_prev) begin
         s_busy    = 1'b1;
         r_wait    = r_delay - 1;
         axi.rdata = mem(hs_addr);
         axi.rid   = hs_id;
      end
      if (s_busy && !axi.rvalid) begin
         if (r_wait == 0) axi.rvalid = 1'b1;
         else r_wait--;
      end
      if (axi.arvalid && stall_cnt >= ar_stall) begin
         axi.arready = 1'b1;
         stall_cnt   = 0;
      end else begin
         axi.arready = 1'b0;
         if (axi.arvalid) stall_cnt++;
      end
   endtask

   // Observes the cycle at negedge and pops the scoreboard.
   task automatic monitor();
      req_t e;
      last_aok_i = inst_sram_addr_ok;
      last_aok_d = data_sram_addr_ok;
      ar_hs_prev = axi.arvalid && axi.arready;
      r_hs_prev  = axi.rvalid && axi.rready;
      if (!resetn) begin
         last_aok_i = 1'b0; last_aok_d = 1'b0; ar_hs_prev = 1'b0; r_hs_prev = 1'b0;
         prev_wait = 1'b0;
         return;
      end
      if (prev_wait) begin
         checks++;
         if ({axi.arvalid, axi.arid, axi.araddr, axi.arsize} !== {1'b1, prev_arid, prev_araddr, prev_arsize}) begin
            errors++;
            $display("FAIL ar_hold: got v=%0b id=%0h addr=%08h size=%0h want v=1 id=%0h addr=%08h size=%0h",
                     axi.arvalid, axi.arid, axi.araddr, axi.arsize, prev_arid, prev_araddr, prev_arsize);
         end
      end
      prev_wait   = axi.arvalid && !axi.arready;
      prev_arid   = axi.arid;
      prev_araddr = axi.araddr;
      prev_arsize = axi.arsize;
      inst_aok_cnt += int'(inst_sram_addr_ok);
      data_aok_cnt += int'(data_sram_addr_ok);
      if (ar_hs_prev) begin
         hs_addr = axi.araddr;
         hs_id   = axi.arid;
         checks++;
         if (exp_ar.size() == 0) begin
            errors++;
            $display("FAIL ar_unexpected: got id=%0h addr=%08h want no AR", axi.arid, axi.araddr);
         end else begin
            e = exp_ar.pop_front();
            if ({axi.arid, axi.araddr, axi.arsize, axi.arlen, axi.arburst, axi.arlock, axi.arcache, axi.arprot,
                 inst_sram_addr_ok, data_sram_addr_ok} !==
                {(e.is_data ? DATA_ID : INST_ID), e.addr, {1'b0, e.size}, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0,
                 !e.is_data, e.is_data}) begin
               errors++;
               $display("FAIL ar_fields: got id=%0h addr=%08h size=%0h len=%0h burst=%0h aok_i=%0b aok_d=%0b want id=%0h addr=%08h size=%0h len=0 burst=1 aok_i=%0b aok_d=%0b",
                        axi.arid, axi.araddr, axi.arsize, axi.arlen, axi.arburst, inst_sram_addr_ok, data_sram_addr_ok,
                        (e.is_data ? DATA_ID : INST_ID), e.addr, {1'b0, e.size}, !e.is_data, e.is_data);
            end
         end
      end else if (inst_sram_addr_ok || data_sram_addr_ok) begin
         checks++; errors++;
         $display("FAIL addr_ok_stray: got aok_i=%0b aok_d=%0b want 0 without AR handshake",
                  inst_sram_addr_ok, data_sram_addr_ok);
      end
      if (r_hs_prev) r_hs_cyc = cyc;
      inst_ok_cnt += int'(inst_sram_data_ok);
      data_ok_cnt += int'(data_sram_data_ok);
      if (inst_sram_data_ok || data_sram_data_ok) begin
         checks++;
         if (exp_r.size() == 0 || (inst_sram_data_ok && data_sram_data_ok)) begin
            errors++;
            $display("FAIL data_ok_unexpected: got ok_i=%0b ok_d=%0b want none (pending=%0d)",
                     inst_sram_data_ok, data_sram_data_ok, exp_r.size());
         end else begin
            e = exp_r.pop_front();
            if (e.is_data) exp_data_rdata = mem(e.addr);
            else           exp_inst_rdata = mem(e.addr);
            if ({data_sram_data_ok, inst_sram_rdata, data_sram_rdata} !==
                {e.is_data, exp_inst_rdata, exp_data_rdata} || cyc != r_hs_cyc + 1) begin
               errors++;
               $display("FAIL data_ok_resp: got ok_d=%0b irdata=%08h drdata=%08h lat=%0d want ok_d=%0b irdata=%08h drdata=%08h lat=1",
                        data_sram_data_ok, inst_sram_rdata, data_sram_rdata, cyc - r_hs_cyc,
                        e.is_data, exp_inst_rdata, exp_data_rdata);
            end
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
      slave_step();
      @(negedge clk);
      monitor();
   endtask

   task automatic push(input logic is_data, input logic [31:0] addr, input logic [1:0] size);
      req_t e;
      e.is_data = is_data; e.addr = addr; e.size = size;
      exp_ar.push_back(e);
      exp_r.push_back(e);
   endtask

   task automatic req_inst(input logic [31:0] addr, input logic [1:0] size);
      inst_sram_req = 1'b1; inst_sram_wr = 1'b0; inst_sram_addr = addr; inst_sram_size = size;
   endtask

   task automatic req_data(input logic [31:0] addr, input logic [1:0] size);
      data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = addr; data_sram_size = size;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while ((exp_r.size() != 0 || exp_ar.size() != 0) && n < 60) begin
         tick();
         n++;
      end
      checks++;
      if (exp_r.size() != 0 || exp_ar.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout: got pending ar=%0d r=%0d want 0", name, exp_ar.size(), exp_r.size());
         exp_ar.delete();
         exp_r.delete();
      end
   endtask

   task automatic test_reset();
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = 32'd0; axi.rid = 4'd0;
      axi.rresp = 2'b00; axi.rlast = 1'b1;
      resetn = 1'b0;
      repeat (3) tick();
      checks++;
      if ({axi.arvalid, axi.rready, axi.arid, axi.araddr, axi.arsize, inst_sram_data_ok, data_sram_data_ok,
           inst_sram_rdata, data_sram_rdata, inst_sram_addr_ok, data_sram_addr_ok} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got arv=%0b rr=%0b id=%0h addr=%08h ok=%0b%0b rd=%08h/%08h want all 0",
                  axi.arvalid, axi.rready, axi.arid, axi.araddr, inst_sram_data_ok, data_sram_data_ok,
                  inst_sram_rdata, data_sram_rdata);
      end
      resetn = 1'b1;
      repeat (2) tick();
   endtask

   task automatic test_inst_read();
      int ai, oi, ad, od;
      ai = inst_aok_cnt; oi = inst_ok_cnt; ad = data_aok_cnt; od = data_ok_cnt;
      ar_stall = 0; r_delay = 2;
      req_inst(32'h1FC0_0000, 2'd2);
      push(1'b0, 32'h1FC0_0000, 2'd2);
      wait_done("inst_read");
      checks++;
      if ({inst_aok_cnt - ai, inst_ok_cnt - oi, data_aok_cnt - ad, data_ok_cnt - od} !== {32'd1, 32'd1, 32'd0, 32'd0}) begin
         errors++;
         $display("FAIL inst_read_pulses: got aok=%0d ok=%0d daok=%0d dok=%0d want 1 1 0 0",
                  inst_aok_cnt - ai, inst_ok_cnt - oi, data_aok_cnt - ad, data_ok_cnt - od);
      end
      checks++;
      if (inst_sram_rdata !== 32'h3C1D_0000) begin
         errors++;
         $display("FAIL inst_read_rdata: got %08h want 3c1d0000", inst_sram_rdata);
      end
      tick();
   endtask

   task automatic test_arbitration();
      r_delay = 1;
      req_data(32'h8000_1000, 2'd2);
      req_inst(32'h1FC0_0010, 2'd2);
      push(1'b1, 32'h8000_1000, 2'd2);
      push(1'b0, 32'h1FC0_0010, 2'd2);
      wait_done("arbitration");
      checks++;
      if ({data_sram_rdata, inst_sram_rdata} !== {mem(32'h8000_1000), mem(32'h1FC0_0010)}) begin
         errors++;
         $display("FAIL arb_rdata: got d=%08h i=%08h want d=%08h i=%08h",
                  data_sram_rdata, inst_sram_rdata, mem(32'h8000_1000), mem(32'h1FC0_0010));
      end
      tick();
   endtask

   task automatic test_write_busy();
      int oi;
      logic data_early;
      oi = inst_ok_cnt;
      data_early = 1'b0;
      r_delay = 1;
      write_busy = 1'b1;
      req_data(32'h8000_2000, 2'd1);
      req_inst(32'h1FC0_0020, 2'd2);
      push(1'b0, 32'h1FC0_0020, 2'd2);
      push(1'b1, 32'h8000_2000, 2'd1);
      repeat (5) begin
         tick();
         if (axi.arvalid && axi.arid == DATA_ID) data_early = 1'b1;
      end
      checks++;
      if ({data_early, inst_ok_cnt - oi} !== {1'b0, 32'd1}) begin
         errors++;
         $display("FAIL write_busy_block: got data_ar_early=%0b inst_ok=%0d want 0 1", data_early, inst_ok_cnt - oi);
      end
      write_busy = 1'b0;
      wait_done("write_busy");
      tick();
   endtask

   task automatic test_ar_stall();
      int n, hold;
      ar_stall = 4; r_delay = 1;
      hold = 0; n = 0;
      req_data(32'h8000_3004, 2'd2);
      push(1'b1, 32'h8000_3004, 2'd2);
      while (n < 20) begin
         tick();
         n++;
         if (axi.arvalid) hold++;
         if (axi.arvalid && axi.arready) break;
      end
      checks++;
      if (hold != 5) begin
         errors++;
         $display("FAIL ar_stall_cycles: got arvalid cycles=%0d want 5", hold);
      end
      ar_stall = 0;
      wait_done("ar_stall");
      tick();
   endtask

   task automatic test_reset_mid();
      int n, oi, od;
      r_delay = 6;
      n = 0;
      req_inst(32'h1FC0_0040, 2'd2);
      push(1'b0, 32'h1FC0_0040, 2'd2);
      while (!axi.rready && n < 10) begin
         tick();
         n++;
      end
      checks++;
      if (axi.rready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid_reach_r: got rready=%0b want 1", axi.rready);
      end
      resetn = 1'b0;
      #1;
      checks++;
      if ({axi.arvalid, axi.rready, axi.arid, axi.araddr, axi.arsize, inst_sram_data_ok, data_sram_data_ok,
           inst_sram_rdata, data_sram_rdata} !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs: got arv=%0b rr=%0b id=%0h addr=%08h rd=%08h/%08h want all 0",
                  axi.arvalid, axi.rready, axi.arid, axi.araddr, inst_sram_rdata, data_sram_rdata);
      end
      exp_ar.delete(); exp_r.delete();
      exp_inst_rdata = 32'd0; exp_data_rdata = 32'd0;
      inst_sram_req = 1'b0;
      repeat (2) tick();
      resetn = 1'b1;
      oi = inst_ok_cnt; od = data_ok_cnt;
      repeat (12) tick();
      checks++;
      if ({inst_ok_cnt - oi, data_ok_cnt - od} !== {32'd0, 32'd0}) begin
         errors++;
         $display("FAIL reset_mid_no_ok: got ok_i=%0d ok_d=%0d want 0 0", inst_ok_cnt - oi, data_ok_cnt - od);
      end
      r_delay = 1;
      req_inst(32'h1FC0_0044, 2'd0);
      push(1'b0, 32'h1FC0_0044, 2'd0);
      wait_done("after_reset");
      checks++;
      if (inst_sram_rdata !== mem(32'h1FC0_0044)) begin
         errors++;
         $display("FAIL after_reset_rdata: got %08h want %08h", inst_sram_rdata, mem(32'h1FC0_0044));
      end
      tick();
   endtask

   task automatic test_write_ignored();
      int ad, od, arv;
      ad = data_aok_cnt; od = data_ok_cnt; arv = 0;
      data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h8000_4000; data_sram_size = 2'd2;
      repeat (8) begin
         tick();
         if (axi.arvalid) arv++;
      end
      checks++;
      if ({arv, data_aok_cnt - ad, data_ok_cnt - od} !== {32'd0, 32'd0, 32'd0}) begin
         errors++;
         $display("FAIL write_ignored: got arvalid=%0d aok=%0d ok=%0d want 0 0 0", arv, data_aok_cnt - ad, data_ok_cnt - od);
      end
      data_sram_req = 1'b0; data_sram_wr = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_inst_read();
      test_arbitration();
      test_write_busy();
      test_ar_stall();
      test_reset_mid();
      test_write_ignored();
      checks++;
      if (exp_ar.size() != 0 || exp_r.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got ar=%0d r=%0d want 0 0", exp_ar.size(), exp_r.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
